ppi_strobed_nport: RTL

//  Clocked, parametrised programmable peripheral interface. Provides NPORTS general I/O ports of

---
 rtl/ppi_strobed_nport.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ppi_strobed_nport.sv
// Clocked programmable peripheral interface: NPORTS ports of PORT_W bits, each configurable as
// basic or strobed input/output with a per-port interrupt; pins use split in/out/oe buses.
module ppi_strobed_nport #(
  parameter int PORT_W = 8,
  parameter int NPORTS = 2,
  parameter int AW     = $clog2(2*NPORTS+1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cs_n,
  input  logic                     rd_n,
  input  logic                     wr_n,
  input  logic [AW-1:0]            addr,
  input  logic [PORT_W-1:0]        din,
  output logic [PORT_W-1:0]        dout,
  output logic                     dout_en,
  input  logic [NPORTS*PORT_W-1:0] pin_in,
  output logic [NPORTS*PORT_W-1:0] pin_out,
  output logic [NPORTS*PORT_W-1:0] pin_oe,
  input  logic [NPORTS-1:0]        stb_n,
  input  logic [NPORTS-1:0]        ack_n,
  output logic [NPORTS-1:0]        ibf,
  output logic [NPORTS-1:0]        obf_n,
  output logic [NPORTS-1:0]        intr
);

  localparam logic [AW-1:0] STATUS_ADDR = AW'(2*NPORTS);

  // Host protocol: an access is a level (cs_n=0 with exactly one of rd_n/wr_n low); its side
  // effects fire once on the first clk of that level, and read data follows one clk later.
  logic w_wr_lvl, w_rd_lvl, r_wr_lvl, r_rd_lvl, w_wr_edge, w_rd_edge, w_st_rd;

  logic [NPORTS-1:0][2:0]        r_cfg;   // {inte, mode, dir}
  logic [NPORTS-1:0][PORT_W-1:0] r_data;
  logic [NPORTS-1:0]             r_ibf, r_obf_n, r_intr, r_ovr;
  logic [NPORTS-1:0]             r_stb_s1, r_stb_s2, r_stb_s3;
  logic [NPORTS-1:0]             r_ack_s1, r_ack_s2, r_ack_s3;
  logic [PORT_W-1:0]             r_dout;
  logic                          r_dout_en;

  logic [NPORTS-1:0] w_dat_wr, w_cfg_wr, w_dat_rd;
  logic [NPORTS-1:0] w_stb_fall, w_ack_fall, w_ack_rise;
  logic [NPORTS-1:0] w_latch, w_ibf_nxt, w_ovr_set;
  logic [PORT_W-1:0] w_status, w_rd_data;

  assign w_wr_lvl  = ~cs_n & ~wr_n & rd_n;
  assign w_rd_lvl  = ~cs_n & ~rd_n & wr_n;
  assign w_wr_edge = w_wr_lvl & ~r_wr_lvl;
  assign w_rd_edge = w_rd_lvl & ~r_rd_lvl;
  assign w_st_rd   = w_rd_edge & (addr == STATUS_ADDR);

  assign w_stb_fall = r_stb_s3 & ~r_stb_s2;
  assign w_ack_fall = r_ack_s3 & ~r_ack_s2;
  assign w_ack_rise = ~r_ack_s3 & r_ack_s2;

  always_comb begin
    w_dat_wr = '0;
    w_cfg_wr = '0;
    w_dat_rd = '0;
    for (int p = 0; p < NPORTS; p++) begin
      w_dat_wr[p] = w_wr_edge & (addr == AW'(p)) & ~r_cfg[p][0];
      w_cfg_wr[p] = w_wr_edge & (addr == AW'(NPORTS + p));
      w_dat_rd[p] = w_rd_edge & (addr == AW'(p));
    end
  end

  // Strobed-input buffer decisions; a host read in the same clk frees the buffer for new data.
  always_comb begin
    w_latch   = '0;
    w_ibf_nxt = r_ibf;
    w_ovr_set = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (r_cfg[p][0] && r_cfg[p][1]) begin
        if (w_stb_fall[p]) begin
          if (w_dat_rd[p] || !r_ibf[p]) begin
            w_latch[p]   = 1'b1;
            w_ibf_nxt[p] = 1'b1;
          end else begin
            w_ovr_set[p] = 1'b1;
          end
        end else if (w_dat_rd[p]) begin
          w_ibf_nxt[p] = 1'b0;
        end
      end
      if (!r_cfg[p][0] && r_cfg[p][1] && w_dat_wr[p] && !r_obf_n[p])
        w_ovr_set[p] = 1'b1;
    end
  end

  always_comb begin
    w_status = '0;
    for (int p = 0; p < NPORTS; p++)
      w_status[4*p +: 4] = {r_ovr[p], r_intr[p], r_cfg[p][2],
                            r_cfg[p][0] ? r_ibf[p] : ~r_obf_n[p]};
  end

  always_comb begin
    w_rd_data = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (addr == AW'(p))          w_rd_data = r_data[p];
      if (addr == AW'(NPORTS + p)) w_rd_data = PORT_W'(r_cfg[p]);
    end
    if (addr == STATUS_ADDR) w_rd_data = w_status;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_lvl  <= 1'b0;
      r_rd_lvl  <= 1'b0;
      r_dout    <= '0;
      r_dout_en <= 1'b0;
      r_stb_s1  <= '1;
      r_stb_s2  <= '1;
      r_stb_s3  <= '1;
      r_ack_s1  <= '1;
      r_ack_s2  <= '1;
      r_ack_s3  <= '1;
    end else begin
      r_wr_lvl  <= w_wr_lvl;
      r_rd_lvl  <= w_rd_lvl;
      r_dout_en <= w_rd_lvl;
      if (w_rd_lvl) r_dout <= w_rd_data;
      r_stb_s1  <= stb_n;
      r_stb_s2  <= r_stb_s1;
      r_stb_s3  <= r_stb_s2;
      r_ack_s1  <= ack_n;
      r_ack_s2  <= r_ack_s1;
      r_ack_s3  <= r_ack_s2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cfg   <= {NPORTS{3'b001}};
      r_data  <= '0;
      r_ibf   <= '0;
      r_obf_n <= '1;
      r_intr  <= '0;
      r_ovr   <= '0;
    end else begin
      if (w_st_rd) r_ovr <= '0;
      for (int p = 0; p < NPORTS; p++) begin
        if (w_cfg_wr[p]) begin
          r_cfg[p]   <= din[2:0];
          r_data[p]  <= '0;
          r_ibf[p]   <= 1'b0;
          r_intr[p]  <= 1'b0;
          r_ovr[p]   <= 1'b0;
          r_obf_n[p] <= 1'b1;
        end else if (r_cfg[p][0]) begin
          r_obf_n[p] <= 1'b1;
          if (!r_cfg[p][1]) begin
            r_data[p] <= pin_in[p*PORT_W +: PORT_W];
            r_ibf[p]  <= 1'b0;
            r_intr[p] <= 1'b0;
          end else begin
            if (w_latch[p]) r_data[p] <= pin_in[p*PORT_W +: PORT_W];
            r_ibf[p]  <= w_ibf_nxt[p];
            r_intr[p] <= r_cfg[p][2] & w_ibf_nxt[p];
            if (w_ovr_set[p]) r_ovr[p] <= 1'b1;
          end
        end else begin
          r_ibf[p] <= 1'b0;
          if (!r_cfg[p][1]) begin
            if (w_dat_wr[p]) r_data[p] <= din;
            r_intr[p]  <= 1'b0;
            r_obf_n[p] <= 1'b1;
          end else if (w_dat_wr[p]) begin
            // A host write takes priority over a coincident acknowledge.
            r_data[p]  <= din;
            r_obf_n[p] <= 1'b0;
            r_intr[p]  <= 1'b0;
            if (w_ovr_set[p]) r_ovr[p] <= 1'b1;
          end else begin
            if (w_ack_fall[p]) r_obf_n[p] <= 1'b1;
            if (w_ack_rise[p] && r_obf_n[p] && r_cfg[p][2]) r_intr[p] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    pin_out = '0;
    pin_oe  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      pin_out[p*PORT_W +: PORT_W] = r_cfg[p][0] ? '0 : r_data[p];
      pin_oe[p*PORT_W +: PORT_W]  = {PORT_W{~r_cfg[p][0]}};
    end
  end

  assign dout    = r_dout;
  assign dout_en = r_dout_en;
  assign ibf     = r_ibf;
  assign obf_n   = r_obf_n;
  assign intr    = r_intr;

endmodule
